// File: rtl/ped_request_ctrl.sv
// Pedestrian requester: conditions the crosswalk button, holds a request to the
// intersection controller until a full walk is served, then enforces a cooldown.
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int WALK_MIN     = 20,
    parameter int REQ_TIMEOUT  = 100,
    parameter int COOLDOWN     = 30,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       walk_green,
    output logic       ped_req,
    output logic       req_pending,
    output logic [7:0] walk_count,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, REQ, WALK, COOL} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_MIN - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] DISP_MAX  = CNT_W'(255);

    logic             sync1, sync2;
    logic             deb, deb_d, press;
    logic [CNT_W-1:0] stab_cnt;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_nx;
    logic [CNT_W-1:0] walk_cnt, walk_nx;
    logic [CNT_W-1:0] cool_cnt, cool_nx;
    logic             latch, latch_nx;
    logic             tmo_nx;
    logic [7:0]       disp_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounced level flips only after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb      <= 1'b0;
            deb_d    <= 1'b0;
            press    <= 1'b0;
            stab_cnt <= '0;
        end else begin
            deb_d <= deb;
            press <= deb & ~deb_d;
            if (sync2 != deb) begin
                if (stab_cnt == DEB_LAST) begin
                    deb      <= sync2;
                    stab_cnt <= '0;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                stab_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            walk_cnt <= '0;
            cool_cnt <= '0;
            latch    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            walk_cnt <= walk_nx;
            cool_cnt <= cool_nx;
            latch    <= latch_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        walk_nx  = walk_cnt;
        cool_nx  = cool_cnt;
        latch_nx = latch;
        tmo_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nx = REQ;
                    wait_nx  = '0;
                end
            end
            REQ: begin
                // A grant on the timeout boundary wins over the timeout pulse.
                if (walk_green) begin
                    state_nx = WALK;
                    walk_nx  = WALK_LAST;
                end else if (wait_cnt == TMO_LAST) begin
                    tmo_nx  = 1'b1;
                    wait_nx = '0;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            WALK: begin
                if (!walk_green) begin
                    state_nx = REQ;
                    wait_nx  = '0;
                end else if (walk_cnt == '0) begin
                    state_nx = COOL;
                    cool_nx  = '0;
                    latch_nx = 1'b0;
                end else begin
                    walk_nx = walk_cnt - 1'b1;
                end
            end
            COOL: begin
                if (cool_cnt >= COOL_LAST && !walk_green) begin
                    // A press on the exit cycle itself still counts as latched.
                    if (latch || press) begin
                        state_nx = REQ;
                        wait_nx  = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                    latch_nx = 1'b0;
                end else begin
                    if (press) latch_nx = 1'b1;
                    if (cool_cnt != {CNT_W{1'b1}}) cool_nx = cool_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        disp_nx = 8'd0;
        if (state_nx == WALK) begin
            if (walk_nx >= DISP_MAX) disp_nx = 8'hFF;
            else                     disp_nx = 8'(walk_nx + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_req     <= 1'b0;
            req_pending <= 1'b0;
            walk_count  <= 8'd0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ped_req     <= (state_nx == REQ) || (state_nx == WALK);
            req_pending <= (state_nx == REQ);
            walk_count  <= disp_nx;
            timeout_err <= tmo_nx;
            busy        <= (state_nx != IDLE);
        end
    end

endmodule

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Pedestrian-side requester for the intersection signal controller; drives that controller's pedestrian request input and watches its walk-green output.
- Synchronises and debounces the raw crosswalk button, then holds the request until a minimum walk interval is served.
- Enforces a cooldown before the next request, and drives the wait lamp and walk countdown display.

Parameters:
- DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a new button level (>=1).
- WALK_MIN, 20, walk_green cycles to serve before the request is released (1..255).
- REQ_TIMEOUT, 100, cycles in REQ without a grant before timeout_err pulses (>=2).
- COOLDOWN, 30, minimum cycles in COOL before a new request may be issued (>=1).
- CNT_W, 16, width of the internal counters; must hold the largest of the above.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  1  raw crosswalk button; asynchronous, bouncy, active-high.
- walk_green  input  1  walk-green from the signal controller; synchronous to clk.
- ped_req  output  1  pedestrian request to the controller; registered.
- req_pending  output  1  wait lamp; high while in REQ.
- walk_count  output  8  remaining walk cycles in WALK; 0 elsewhere.
- timeout_err  output  1  one-cycle pulse on request starvation.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, both sync flops 0, debounced level 0, all counters 0, press_latch 0. Every output is 0.
- Reset mid-operation aborts immediately; ped_req drops without waiting for walk completion.
- Input conditioning:
  - btn_raw passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles.
  - Any cycle of agreement clears the stability counter.
  - A press event is a single-cycle pulse on the debounced 0->1 transition. Releases generate nothing.
- Latency: a clean btn_raw rise seen at edge 0 gives ped_req=1 after edge DEBOUNCE_CYC+3 (7 cycles at default).
- All outputs are registered and decoded from next-state.
- IDLE:
  - ped_req=0.
  - Press event -> REQ; the wait counter clears.
- REQ:
  - ped_req=1, req_pending=1.
  - walk_green=1 -> WALK; the walk counter loads WALK_MIN-1 and walk_count=WALK_MIN.
  - Otherwise the wait counter increments.
  - When the wait counter reaches REQ_TIMEOUT-1: timeout_err pulses one cycle, the counter wraps to 0, and the block stays in REQ (the request is never withdrawn).
  - Further presses are ignored.
- WALK:
  - ped_req=1, req_pending=0.
  - Each cycle with walk_green=1 decrements the counter; walk_count shows counter+1, saturated to 8 bits.
  - Counter=0 with walk_green=1 -> COOL; ped_req=0 on the next cycle.
  - walk_green=0 before expiry (early revoke) -> REQ with the wait counter cleared. The walk is re-requested in full on the next grant; no timeout_err.
  - Presses are ignored.
- COOL:
  - ped_req=0.
  - The cooldown counter counts up from 0.
  - Exit requires both counter >= COOLDOWN-1 and walk_green=0. If walk_green stays high, remain in COOL.
  - A press event in COOL sets press_latch.
  - On exit: press_latch=1 -> REQ (latch cleared); otherwise -> IDLE.
- Simultaneous events:
  - In REQ, a grant arriving on the same cycle as the timeout boundary takes priority: go to WALK, no timeout_err.
  - A press event on the exact COOL-exit cycle counts as latched and goes to REQ.
- Counter widths: CNT_W bits, no wrap except the REQ wait counter. walk_count saturates to 255 if WALK_MIN > 255.
- Protocol contract: ped_req never deasserts in REQ/WALK except on completion, early revoke to REQ (stays high), or reset.

Test Plan:
1. btn_raw bounce pulses of 2 cycles high / 2 cycles low for 20 cycles, then low -> ped_req stays 0, busy stays 0.
2. Clean press held high from cycle 0; walk_green driven high at cycle 15 and held -> ped_req=1 after edge 7, req_pending 1 on cycles 8-15. WALK entered; walk_count reads 20,19,...,1. ped_req=0 one cycle after the 20th grant cycle.
3. Press with no grant for 250 cycles -> timeout_err pulses exactly twice, 100 cycles apart. ped_req stays 1 throughout.
4. Grant for 5 cycles, then walk_green=0 -> return to REQ with ped_req still 1. On the next grant walk_count reloads to 20.
5. Press during COOL at cycle 10, walk_green low -> COOL lasts 30 cycles, then direct REQ with ped_req=1 and no IDLE cycle. Repeat with walk_green held high through cycle 40 -> COOL extends until walk_green falls.
6. Assert reset during WALK with walk_count=12 -> all outputs 0 immediately (asynchronously). After release, state is IDLE and a press is needed to re-request.
